add_accumulator: RTL

ADD_ACCUMULATOR -- requirements
Module: add_accumulator

---
 rtl/add_accumulator_pkg.sv | 13 +
 rtl/add_accumulator_if.sv | 28 ++
 rtl/add_accumulator_fa.sv | 21 ++
 rtl/add_accumulator.sv | 103 ++++++++++
 4 files changed

// File: rtl/add_accumulator_pkg.sv
// Shared definitions for the add accumulator: FSM state encoding and counter sizing.
package add_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } acc_state_t;

  localparam int              CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/add_accumulator_if.sv
// Operand/result bus of the add accumulator.
// The master drives operands and takes results; the slave is the accumulator.
interface add_accumulator_if;
  import add_accumulator_pkg::*;

  logic             clear;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_sum;
  logic [CNT_W-1:0] out_carries;
  logic [CNT_W-1:0] out_ops;
  logic             out_sat;

  modport master (
    output clear, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carries, out_ops, out_sat
  );

  modport slave (
    input  clear, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carries, out_ops, out_sat
  );

endinterface

// File: rtl/add_accumulator_fa.sv
// 8-bit ripple-carry adder built from a chain of one-bit full adders.
module FA_8Bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[8];

endmodule

// File: rtl/add_accumulator.sv
// Accumulates a stream of 8-bit operands into a wrapping sum, counting carry-outs
// and operands, and hands the result over with a valid/ready handshake.
module add_accumulator
  import add_accumulator_pkg::*;
#(
  parameter int MAX_OPS = 15
) (
  input logic                clk,
  input logic                rst,
  add_accumulator_if.slave   bus
);

  localparam logic [CNT_W-1:0] MAX_OPS_C = CNT_W'(MAX_OPS);

  acc_state_t       state, state_nxt;
  logic [7:0]       acc, acc_nxt;
  logic [CNT_W-1:0] carries, carries_nxt;
  logic [CNT_W-1:0] ops, ops_nxt;
  logic             sat, sat_nxt;

  logic [7:0]       add_sum;
  logic             add_cout;

  // The running total always feeds the adder; its result is used only on an accept in ACCUM.
  FA_8Bit u_adder (
    .a    (acc),
    .b    (bus.in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State and datapath registers; reset discards any partial or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      carries <= '0;
      ops     <= '0;
      sat     <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      carries <= carries_nxt;
      ops     <= ops_nxt;
      sat     <= sat_nxt;
    end
  end

  // Next-state and datapath update; clear beats both operand accept and result handoff.
  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    carries_nxt = carries;
    ops_nxt     = ops;
    sat_nxt     = sat;

    if (bus.clear) begin
      state_nxt   = IDLE;
      acc_nxt     = '0;
      carries_nxt = '0;
      ops_nxt     = '0;
      sat_nxt     = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc_nxt     = bus.in_data;
            carries_nxt = '0;
            ops_nxt     = CNT_W'(1);
            sat_nxt     = 1'b0;
            state_nxt   = (bus.in_last || MAX_OPS == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            acc_nxt     = add_sum;
            carries_nxt = (carries == CNT_MAX) ? CNT_MAX : carries + CNT_W'(add_cout);
            sat_nxt     = sat | (add_cout & (carries == CNT_MAX));
            ops_nxt     = ops + CNT_W'(1);
            state_nxt   = (bus.in_last || ops_nxt == MAX_OPS_C) ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = (state != DONE);
  assign bus.out_valid   = (state == DONE);
  assign bus.out_sum     = acc;
  assign bus.out_carries = carries;
  assign bus.out_ops     = ops;
  assign bus.out_sat     = sat;

endmodule
